// File: rtl/fire_scheduler.sv
// Fire scheduler: each cycle picks one enabled transition to fire, either
// round-robin from a rotating pointer or from an LFSR-chosen start point,
// and watches for deadlock (nothing enabled) and starvation (an enabled
// transition left waiting too long).
module fire_scheduler #(
    parameter int NTRANS       = 8,
    parameter int FW           = 4,
    parameter int DL_LIMIT     = 15,
    parameter int STARVE_LIMIT = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NTRANS-1:0] ena,
    input  logic              hold,
    input  logic              mode,
    input  logic [15:0]       seed,
    output logic [FW-1:0]     fire,
    output logic              deadlock,
    output logic              starved,
    output logic [FW-1:0]     starved_idx
);

    localparam int DW = $clog2(DL_LIMIT + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [FW-1:0] NONE   = FW'(NTRANS);
    localparam logic [FW:0]   NT_EXT = (FW+1)'(NTRANS);

    logic [FW-1:0]     ptr;
    logic [15:0]       lfsr;
    logic [DW-1:0]     idle_cnt;
    logic [SW-1:0]     wait_cnt [NTRANS];

    logic [FW-1:0]     start;
    logic [NTRANS-1:0] ena_rot;
    logic              found;
    logic [FW-1:0]     offset;
    logic [FW:0]       sum;
    logic [FW-1:0]     sel_idx;
    logic              lfsr_fb;
    logic              hit;
    logic [FW-1:0]     hit_idx;

    // Search start point: the rotating pointer, or the LFSR folded into range.
    always_comb begin
        start = mode ? FW'(lfsr % 16'(NTRANS)) : ptr;
    end

    // Rotate ena so the start index sits at bit 0, take the lowest set bit,
    // then map that offset back to an absolute transition index.
    always_comb begin
        ena_rot = NTRANS'({ena, ena} >> start);
        found   = 1'b0;
        offset  = '0;
        for (int j = NTRANS - 1; j >= 0; j--) begin
            if (ena_rot[j]) begin
                found  = 1'b1;
                offset = FW'(j);
            end
        end
        sum = {1'b0, start} + {1'b0, offset};
        if (sum >= NT_EXT) begin
            sum = sum - NT_EXT;
        end
        sel_idx = sum[FW-1:0];
    end

    // Feedback for the 16-bit Fibonacci LFSR with taps 16,14,13,11.
    always_comb begin
        lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    end

    // Lowest transition whose wait counter has hit the starvation limit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int j = NTRANS - 1; j >= 0; j--) begin
            if (wait_cnt[j] == SW'(STARVE_LIMIT)) begin
                hit     = 1'b1;
                hit_idx = FW'(j);
            end
        end
    end

    // Fire register, pointer, LFSR, idle counter and the sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            fire        <= NONE;
            ptr         <= '0;
            lfsr        <= (seed == 16'h0000) ? 16'hACE1 : seed;
            idle_cnt    <= '0;
            deadlock    <= 1'b0;
            starved     <= 1'b0;
            starved_idx <= '0;
        end else if (!hold) begin
            fire <= found ? sel_idx : NONE;
            if (!mode && found) begin
                ptr <= (sel_idx == FW'(NTRANS - 1)) ? '0 : sel_idx + FW'(1);
            end
            lfsr <= {lfsr[14:0], lfsr_fb};
            if (ena == '0) begin
                if (idle_cnt != DW'(DL_LIMIT)) begin
                    idle_cnt <= idle_cnt + DW'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
            if (idle_cnt == DW'(DL_LIMIT)) begin
                deadlock <= 1'b1;
            end
            if (!starved && hit) begin
                starved     <= 1'b1;
                starved_idx <= hit_idx;
            end
        end
    end

    // Per-transition wait counters; sel_idx only counts as served when found.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NTRANS; i++) begin
            if (reset) begin
                wait_cnt[i] <= '0;
            end else if (!hold) begin
                if (ena[i] && !(found && sel_idx == FW'(i))) begin
                    if (wait_cnt[i] != SW'(STARVE_LIMIT)) begin
                        wait_cnt[i] <= wait_cnt[i] + SW'(1);
                    end
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fire_scheduler.sv
// Self-checking bench for fire_scheduler against a behavioural model.
module tb_fire_scheduler;

    localparam int NTRANS       = 8;
    localparam int DL_LIMIT     = 15;
    localparam int STARVE_LIMIT = 31;

    logic       clk;
    logic       reset;
    logic [7:0] ena;
    logic       hold;
    logic       mode;
    logic [15:0] seed;
    logic [3:0] fire;
    logic       deadlock;
    logic       starved;
    logic [3:0] starved_idx;

    int total = 0;
    int bad   = 0;

    int m_fire, m_ptr, m_lfsr, m_idle, m_stidx;
    int m_wait [NTRANS];
    bit m_dl, m_st;
    logic [7:0] last_ena;
    bit seen [NTRANS];
    int star_seed;

    fire_scheduler #(.NTRANS(8), .FW(4), .DL_LIMIT(15), .STARVE_LIMIT(31)) dut (
        .clk(clk), .reset(reset), .ena(ena), .hold(hold), .mode(mode), .seed(seed),
        .fire(fire), .deadlock(deadlock), .starved(starved), .starved_idx(starved_idx)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int lfsrNext(input int l);
        int fb;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return ((l << 1) | fb) & 32'hFFFF;
    endfunction

    // Reference model: one clock edge worth of behaviour from the rules.
    task automatic modelStep(input bit r, input bit h, input bit md, input logic [7:0] e);
        int start, sel, t;
        if (r) begin
            m_fire = NTRANS; m_ptr = 0; m_idle = 0; m_dl = 0; m_st = 0; m_stidx = 0;
            m_lfsr = (seed == 0) ? 32'hACE1 : int'(seed);
            for (int i = 0; i < NTRANS; i++) m_wait[i] = 0;
        end else if (!h) begin
            start = md ? (m_lfsr % NTRANS) : m_ptr;
            sel = -1;
            for (int k = 0; k < NTRANS; k++) begin
                t = (start + k) % NTRANS;
                if (sel < 0 && ((e >> t) & 1) == 1) sel = t;
            end
            for (int i = 0; i < NTRANS; i++) begin
                if (!m_st && m_wait[i] == STARVE_LIMIT) begin
                    m_st = 1; m_stidx = i;
                end
            end
            if (m_idle == DL_LIMIT) m_dl = 1;
            if (e == 0) m_idle = (m_idle < DL_LIMIT) ? m_idle + 1 : DL_LIMIT;
            else m_idle = 0;
            for (int i = 0; i < NTRANS; i++) begin
                if (((e >> i) & 1) == 1 && i != sel)
                    m_wait[i] = (m_wait[i] < STARVE_LIMIT) ? m_wait[i] + 1 : STARVE_LIMIT;
                else
                    m_wait[i] = 0;
            end
            m_fire = (sel < 0) ? NTRANS : sel;
            if (!md && sel >= 0) m_ptr = (sel + 1) % NTRANS;
            m_lfsr = lfsrNext(m_lfsr);
        end
    endtask

    // Drive one cycle, advance the model, then compare on the falling edge.
    task automatic applyStimulus(input bit r, input bit h, input bit md, input logic [7:0] e);
        reset = r; hold = h; mode = md; ena = e;
        modelStep(r, h, md, e);
        if (!r && !h) last_ena = e;
        @(posedge clk);
        @(negedge clk);
        checkOutput("fire", int'(fire), m_fire);
        checkOutput("deadlock", int'(deadlock), int'(m_dl));
        checkOutput("starved", int'(starved), int'(m_st));
        checkOutput("starved_idx", int'(starved_idx), m_stidx);
        checkOutput("fire_range", int'(fire <= 4'(NTRANS)), 1);
        if (!r && fire < 4'(NTRANS)) begin
            checkOutput("fire_ena_bit", int'(last_ena[fire[2:0]]), 1);
            seen[fire[2:0]] = 1'b1;
        end
    endtask

    // Find a seed whose LFSR start points avoid index 3 for 31 cycles in a row.
    function automatic int findStarveSeed();
        int l, w;
        for (int s = 1; s < 65536; s++) begin
            l = s; w = 0;
            for (int step = 0; step < 300; step++) begin
                if (l % NTRANS == 3) w = 0;
                else w++;
                if (w >= 31) return s;
                l = lfsrNext(l);
            end
        end
        return 0;
    endfunction

    // Directed scenarios followed by randomized traffic.
    initial begin
        int exp30 [3];
        exp30 = '{5, 2, 5};
        reset = 1'b1; hold = 1'b0; mode = 1'b0; ena = '0; seed = '0; last_ena = '0;

        // Reset state, with hold high to show reset wins.
        applyStimulus(1, 1, 0, 8'hFF);
        checkOutput("reset_fire", int'(fire), 8);
        checkOutput("reset_flags", int'({deadlock, starved}), 0);
        checkOutput("reset_idx", int'(starved_idx), 0);

        // Round-robin over all-enabled.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 8'hFF);
            checkOutput("rr_seq", int'(fire), i % 8);
        end

        // Sparse enables with pointer parked at 3.
        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h04);
        checkOutput("sparse_first", int'(fire), 2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 8'h24);
            checkOutput("sparse_seq", int'(fire), exp30[i]);
        end

        // Hold freezes everything, then round-robin resumes.
        applyStimulus(1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 8'($urandom));
            checkOutput("hold_fire", int'(fire), 2);
        end
        applyStimulus(0, 0, 0, 8'hFF);
        checkOutput("hold_resume", int'(fire), 3);
        applyStimulus(0, 0, 0, 8'hFF);
        checkOutput("hold_resume2", int'(fire), 4);

        // Deadlock after 15 idle cycles, sticky afterwards.
        applyStimulus(1, 0, 0, 8'h00);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 0, 0, 8'h00);
            checkOutput("idle_fire", int'(fire), 8);
            checkOutput("dl_timing", int'(deadlock), (i == 16) ? 1 : 0);
        end
        applyStimulus(0, 0, 0, 8'h01);
        checkOutput("dl_recover_fire", int'(fire), 0);
        checkOutput("dl_sticky", int'(deadlock), 1);

        // Random mode with zero seed: first start is 16'hACE1 mod 8 = 1.
        seed = 16'h0000;
        applyStimulus(1, 0, 1, 8'h00);
        for (int i = 0; i < NTRANS; i++) seen[i] = 1'b0;
        applyStimulus(0, 0, 1, 8'hFF);
        checkOutput("lfsr_seed_zero", int'(fire), 1);
        for (int i = 0; i < 1000; i++) applyStimulus(0, 0, 1, 8'($urandom));
        for (int i = 0; i < NTRANS; i++) checkOutput("index_seen", int'(seen[i]), 1);

        // Mixed traffic: random mode switches and holds.
        seed = 16'($urandom);
        applyStimulus(1, 0, 0, 8'h00);
        for (int i = 0; i < 300; i++)
            applyStimulus(0, ($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom));

        // Forced starvation of index 3 in random mode.
        star_seed = findStarveSeed();
        checkOutput("seed_found", int'(star_seed != 0), 1);
        seed = 16'(star_seed);
        applyStimulus(1, 0, 1, 8'h00);
        for (int c = 0; c < 400 && !m_st; c++) applyStimulus(0, 0, 1, 8'h0C);
        checkOutput("starve_flag", int'(starved), 1);
        checkOutput("starve_index", int'(starved_idx), 3);
        applyStimulus(0, 0, 1, 8'h0C);
        checkOutput("starve_sticky", int'(starved), 1);

        // Reset mid-run returns every output to its initial value.
        applyStimulus(1, 1, 1, 8'($urandom));
        checkOutput("midreset_fire", int'(fire), 8);
        checkOutput("midreset_flags", int'({deadlock, starved}), 0);
        checkOutput("midreset_idx", int'(starved_idx), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fire_scheduler.md
FIRE_SCHEDULER -- requirements
Module: fire_scheduler

Interface
REQ-001 Parameter NTRANS, default 8: number of transitions (input transitions first, then stateful gates, in fire-index order).
REQ-002 Parameter FW, default 4: fire width, the smallest width able to hold NTRANS (NTRANS itself is the "none" code).
REQ-003 Parameter DL_LIMIT, default 15: consecutive no-fire cycles before deadlock is flagged.
REQ-004 Parameter STARVE_LIMIT, default 31: cycles an enabled transition may wait before starvation is flagged.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous, active-high; sampled on the rising clk edge.
REQ-007 ena  in  NTRANS  per-transition enable: bit i high means transition i may fire this cycle.
REQ-008 hold  in  1  freeze: keep fire, pointer and counters unchanged.
REQ-009 mode  in  1  0 = round-robin selection, 1 = pseudo-random (LFSR) selection.
REQ-010 seed  in  16  LFSR seed, loaded at reset; a zero seed is replaced by 16'hACE1.
REQ-011 fire  out  FW  registered index of the transition fired this cycle; NTRANS means none.
REQ-012 deadlock  out  1  sticky: no transition was enabled for DL_LIMIT consecutive cycles.
REQ-013 starved  out  1  sticky: some enabled transition waited STARVE_LIMIT cycles unserved.
REQ-014 starved_idx  out  FW  lowest index that caused starved; valid while starved is high.

Function
REQ-015 fire shall change only on a rising clk edge and stay stable for the whole following cycle (the downstream monitor samples it on the falling edge).
REQ-016 Each cycle without hold, the next fire value shall be computed from the current ena: the selected enabled index, or NTRANS when ena is all zero. Latency is one cycle from ena to fire.
REQ-017 Round-robin (mode 0): search ena from index ptr upward, wrapping at NTRANS-1 back to 0; the first set bit is selected; ptr then becomes selected index + 1, wrapping to 0 past NTRANS-1.
REQ-018 When no transition is selected, ptr shall not change.
REQ-019 Random (mode 1): a 16-bit Fibonacci LFSR (taps 16,14,13,11) shall advance once per non-hold cycle; the search start is (lfsr mod NTRANS), then wraps as in REQ-017; ptr is not updated in mode 1.
REQ-020 A mode change shall take effect on the next decision cycle without resetting ptr or the LFSR.
REQ-021 Idle counter: increments (saturating at DL_LIMIT) in each non-hold cycle with ena == 0; clears in any non-hold cycle with ena != 0. deadlock shall assert in the cycle after the counter reaches DL_LIMIT and stay high until reset.
REQ-022 Per-transition wait counters: counter i increments (saturating at STARVE_LIMIT) when ena[i] is high and i is not selected; it clears when i is selected or ena[i] is low.
REQ-023 starved shall assert, and starved_idx latch the lowest index whose counter reached STARVE_LIMIT, in the following cycle; both stay unchanged until reset.
REQ-024 hold high: fire, ptr, LFSR, the idle counter and all wait counters shall retain their values; deadlock and starved shall retain their values.
REQ-025 fire shall never be greater than NTRANS, and shall never name an index whose ena bit was low in the deciding cycle.

Reset
REQ-026 In any cycle with reset high: fire = NTRANS, ptr = 0, LFSR = seed (or 16'hACE1 if seed is zero), all counters = 0, deadlock = 0, starved = 0, starved_idx = 0.
REQ-027 Reset overrides hold, and shall abort any in-progress counting.
REQ-028 The first decision shall occur in the first cycle after reset deasserts.

Verification
REQ-029 NTRANS=8, mode 0, ena=8'hFF held for 10 cycles -> fire sequence 0,1,...,7,0,1; deadlock and starved both stay 0.
REQ-030 mode 0, ena=8'b0010_0100, ptr=3 -> fire=5, then 2, then 5; bits outside ena are never selected.
REQ-031 ena=0 for 15 cycles -> fire=8 throughout; deadlock rises on cycle 16. Then ena=8'h01 -> fire=0, deadlock stays 1 until reset.
REQ-032 mode 1, seed=0 -> LFSR reset value is 16'hACE1. Over 1000 cycles with random ena: every fire has its ena bit set in the deciding cycle, and all indices 0..7 appear.
REQ-033 hold=1 for 5 cycles mid-sequence with ena changing -> fire and the counters are unchanged; after hold falls, the round-robin sequence resumes from the saved ptr.
REQ-034 Forced starvation: in mode 1, hold ena[3] high while the LFSR repeatedly skips index 3 -> starved=1 and starved_idx=3 one cycle after the wait count reaches 31; reset asserted mid-run -> all outputs return to their REQ-026 values the next cycle.
